gshare_branch_predictor: RTL and testbench

Parametrised fetch-stage branch predictor that generalises the local two-bit/BTB predictor. It adds a global history register (gshare indexing of the pattern table), a tagged branch target buffer, saturating-counter training and mispredict statistics. It sits beside the PC register: fetch supplies the current PC and receives the next-PC guess, and the execute stage trains the predictor when a branch resolves.

---
 rtl/rv32i_types.sv | 24 ++
 rtl/predictor_array.sv | 37 +++
 rtl/gshare_branch_predictor.sv | 118 +++++++++++
 tb/tb_gshare_branch_predictor.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared types for the fetch-stage predictor.
//   prediction_t : two-bit saturating direction counter, ordered snt < wnt < wt < st
//   sat_step     : one training step of a counter toward st (up=1) or snt (up=0)
package rv32i_types;

  typedef enum logic [1:0] {
    snt = 2'b00,
    wnt = 2'b01,
    wt  = 2'b10,
    st  = 2'b11
  } prediction_t;

  function automatic prediction_t sat_step(input prediction_t cur, input logic up);
    prediction_t nxt;
    nxt = cur;
    if (up) begin
      if (cur != st) nxt = prediction_t'(cur + 2'd1);
    end else begin
      if (cur != snt) nxt = prediction_t'(cur - 2'd1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/predictor_array.sv
// Small register array used for the PHT and each BTB field.
//   clk, rst          : clock, async active-low reset (every entry -> RESET_VALUE)
//   rd_index/rd_data  : READ_PORTS combinational read ports
//   wr_en/wr_index/wr_data : synchronous write port
module predictor_array #(
  parameter int              WIDTH       = 2,
  parameter int              INDEX_BITS  = 5,
  parameter int              READ_PORTS  = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_index [READ_PORTS],
  output logic [WIDTH-1:0]      rd_data  [READ_PORTS],
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [WIDTH-1:0]      wr_data
);

  localparam int DEPTH = 1 << INDEX_BITS;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VALUE;
    end else if (wr_en) begin
      mem[wr_index] <= wr_data;
    end
  end

  // Reads see pre-write contents; a same-cycle write lands at the edge.
  always_comb begin
    for (int p = 0; p < READ_PORTS; p++) rd_data[p] = mem[rd_index[p]];
  end

endmodule

// File: rtl/gshare_branch_predictor.sv
// Gshare direction predictor with tagged BTB and resolve statistics.
//   lookup : current_pc -> prediction, predict_taken, btb_hit, pc_prediction, pht_index
//   train  : update, pc_update, update_index, taken, calculated_target, mispredict
//   history: ghr_clear (synchronous, beats a same-cycle shift)
//   stats  : branch_count, mispredict_count (saturating)
module gshare_branch_predictor
  import rv32i_types::*;
#(
  parameter int INDEX_BITS = 5,
  parameter int GHR_BITS   = 5,
  parameter int TAG_BITS   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           current_pc,
  output prediction_t           prediction,
  output logic                  predict_taken,
  output logic                  btb_hit,
  output logic [31:0]           pc_prediction,
  output logic [INDEX_BITS-1:0] pht_index,
  input  logic                  update,
  input  logic [31:0]           pc_update,
  input  logic [INDEX_BITS-1:0] update_index,
  input  logic                  taken,
  input  logic [31:0]           calculated_target,
  input  logic                  mispredict,
  input  logic                  ghr_clear,
  output logic [31:0]           branch_count,
  output logic [31:0]           mispredict_count
);

  logic [GHR_BITS-1:0]   ghr;
  logic [GHR_BITS:0]     ghr_shifted;
  logic [INDEX_BITS-1:0] btb_index;
  logic [INDEX_BITS-1:0] btb_wr_index;
  logic [TAG_BITS-1:0]   lookup_tag;
  logic [TAG_BITS-1:0]   update_tag;
  logic [31:0]           branch_count_q;
  logic [31:0]           mispredict_count_q;
  logic                  btb_write;
  prediction_t           pht_next;

  logic [INDEX_BITS-1:0] pht_rd_index [2];
  logic [1:0]            pht_rd_data  [2];
  logic [INDEX_BITS-1:0] btb_rd_index [1];
  logic [0:0]            valid_rd     [1];
  logic [TAG_BITS-1:0]   tag_rd       [1];
  logic [31:0]           target_rd    [1];

  assign btb_index    = current_pc[INDEX_BITS+1:2];
  assign lookup_tag   = current_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign btb_wr_index = pc_update[INDEX_BITS+1:2];
  assign update_tag   = pc_update[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign pht_index    = btb_index ^ INDEX_BITS'(ghr);

  // Port 0 serves fetch, port 1 reads the counter being trained.
  assign pht_rd_index[0] = pht_index;
  assign pht_rd_index[1] = update_index;
  assign btb_rd_index[0] = btb_index;

  assign pht_next  = sat_step(prediction_t'(pht_rd_data[1]), taken);
  assign btb_write = update && taken;

  predictor_array #(.WIDTH(2), .INDEX_BITS(INDEX_BITS), .READ_PORTS(2), .RESET_VALUE(2'(wnt)))
    u_pht (.clk(clk), .rst(rst), .rd_index(pht_rd_index), .rd_data(pht_rd_data),
           .wr_en(update), .wr_index(update_index), .wr_data(pht_next));

  predictor_array #(.WIDTH(1), .INDEX_BITS(INDEX_BITS), .READ_PORTS(1), .RESET_VALUE(1'b0))
    u_btb_valid (.clk(clk), .rst(rst), .rd_index(btb_rd_index), .rd_data(valid_rd),
                 .wr_en(btb_write), .wr_index(btb_wr_index), .wr_data(1'b1));

  predictor_array #(.WIDTH(TAG_BITS), .INDEX_BITS(INDEX_BITS), .READ_PORTS(1), .RESET_VALUE('0))
    u_btb_tag (.clk(clk), .rst(rst), .rd_index(btb_rd_index), .rd_data(tag_rd),
               .wr_en(btb_write), .wr_index(btb_wr_index), .wr_data(update_tag));

  predictor_array #(.WIDTH(32), .INDEX_BITS(INDEX_BITS), .READ_PORTS(1), .RESET_VALUE('0))
    u_btb_target (.clk(clk), .rst(rst), .rd_index(btb_rd_index), .rd_data(target_rd),
                  .wr_en(btb_write), .wr_index(btb_wr_index), .wr_data(calculated_target));

  assign prediction    = prediction_t'(pht_rd_data[0]);
  assign predict_taken = (prediction == wt) || (prediction == st);
  assign btb_hit       = valid_rd[0][0] && (tag_rd[0] == lookup_tag);
  assign pc_prediction = (btb_hit && predict_taken) ? target_rd[0] : current_pc + 32'd4;

  // Appending taken and dropping the MSB also covers GHR_BITS == 1.
  assign ghr_shifted = {ghr, taken};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ghr <= '0;
    end else if (ghr_clear) begin
      ghr <= '0;
    end else if (update) begin
      ghr <= ghr_shifted[GHR_BITS-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else if (update) begin
      if (branch_count_q != '1) branch_count_q <= branch_count_q + 32'd1;
      if (mispredict && (mispredict_count_q != '1))
        mispredict_count_q <= mispredict_count_q + 32'd1;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

  // Byte-offset bits and PC bits above the tag never take part in lookup.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{current_pc[1:0], pc_update[1:0],
                            32'(current_pc >> (INDEX_BITS + TAG_BITS + 2)),
                            32'(pc_update  >> (INDEX_BITS + TAG_BITS + 2))};

endmodule

// File: tb/tb_gshare_branch_predictor.sv
module tb_gshare_branch_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] current_pc = '0;
  logic [1:0]  prediction;
  logic        predict_taken;
  logic        btb_hit;
  logic [31:0] pc_prediction;
  logic [4:0]  pht_index;
  logic        update = 1'b0;
  logic [31:0] pc_update = '0;
  logic [4:0]  update_index = '0;
  logic        taken = 1'b0;
  logic [31:0] calculated_target = '0;
  logic        mispredict = 1'b0;
  logic        ghr_clear = 1'b0;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int total = 0;
  int bad   = 0;

  gshare_branch_predictor dut (
    .clk(clk), .rst(rst), .current_pc(current_pc),
    .prediction(prediction), .predict_taken(predict_taken), .btb_hit(btb_hit),
    .pc_prediction(pc_prediction), .pht_index(pht_index),
    .update(update), .pc_update(pc_update), .update_index(update_index),
    .taken(taken), .calculated_target(calculated_target), .mispredict(mispredict),
    .ghr_clear(ghr_clear), .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  // Reference model: counters held as integers 0..3 (snt..st).
  int          m_pht [32];
  bit          m_valid [32];
  logic [7:0]  m_tag [32];
  logic [31:0] m_tgt [32];
  int          m_ghr;
  longint      m_bc, m_mc;

  logic [4:0]  e_idx;
  logic [1:0]  e_pred;
  logic        e_hit;
  logic [31:0] e_next;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_pht[i] = 1; m_valid[i] = 0; m_tag[i] = '0; m_tgt[i] = '0;
    end
    m_ghr = 0; m_bc = 0; m_mc = 0;
  endfunction

  function automatic logic [4:0] model_idx(input logic [31:0] pc);
    return 5'(((pc >> 2) & 32'h1F) ^ 32'(m_ghr));
  endfunction

  function automatic void model_lookup(input logic [31:0] pc);
    int b;
    b      = int'((pc >> 2) & 32'h1F);
    e_idx  = model_idx(pc);
    e_pred = 2'(m_pht[e_idx]);
    e_hit  = m_valid[b] && (m_tag[b] == 8'((pc >> 7) & 32'hFF));
    e_next = (e_hit && m_pht[e_idx] >= 2) ? m_tgt[b] : pc + 32'd4;
  endfunction

  function automatic void model_commit();
    int b;
    if (update) begin
      if (taken) m_pht[update_index] = (m_pht[update_index] == 3) ? 3 : m_pht[update_index] + 1;
      else       m_pht[update_index] = (m_pht[update_index] == 0) ? 0 : m_pht[update_index] - 1;
      if (taken) begin
        b = int'((pc_update >> 2) & 32'h1F);
        m_valid[b] = 1; m_tag[b] = 8'((pc_update >> 7) & 32'hFF); m_tgt[b] = calculated_target;
      end
      m_ghr = ghr_clear ? 0 : ((m_ghr * 2) + int'(taken)) % 32;
      if (m_bc < 64'hFFFF_FFFF) m_bc++;
      if (mispredict && m_mc < 64'hFFFF_FFFF) m_mc++;
    end else if (ghr_clear) begin
      m_ghr = 0;
    end
  endfunction

  task automatic drive(input logic [31:0] cpc, input logic upd, input logic [31:0] pu,
                       input logic [4:0] ui, input logic tk, input logic [31:0] tg,
                       input logic mp, input logic clr);
    @(negedge clk);
    current_pc = cpc; update = upd; pc_update = pu; update_index = ui;
    taken = tk; calculated_target = tg; mispredict = mp; ghr_clear = clr;
  endtask

  task automatic commit();
    @(posedge clk);
    #1;
    model_commit();
    update = 1'b0; ghr_clear = 1'b0; mispredict = 1'b0;
  endtask

  task automatic apply_reset();
    update = 1'b0; ghr_clear = 1'b0;
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    drive(32'h100, 0, 0, 0, 0, 0, 0, 0);
    #1;
    total++; if (btb_hit !== 1'b0) begin bad++; $display("FAIL reset_hit got=%b exp=0", btb_hit); end
    total++; if (prediction !== 2'b01) begin bad++; $display("FAIL reset_pred got=%b exp=01", prediction); end
    total++; if (predict_taken !== 1'b0) begin bad++; $display("FAIL reset_taken got=%b exp=0", predict_taken); end
    total++; if (pc_prediction !== 32'h104) begin bad++; $display("FAIL reset_next got=%h exp=104", pc_prediction); end
    total++; if (branch_count !== 32'd0 || mispredict_count !== 32'd0) begin
      bad++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", branch_count, mispredict_count); end
  endtask

  // Repeated taken training: GHR saturates to all ones, so index 0^31 gets two steps -> st.
  task automatic test_training();
    for (int i = 0; i < 7; i++) begin
      drive(32'h100, 1, 32'h100, model_idx(32'h100), 1, 32'h200, 0, 0);
      commit();
    end
    drive(32'h100, 0, 0, 0, 0, 0, 0, 0);
    #1;
    total++; if (pht_index !== 5'd31) begin bad++; $display("FAIL train_idx got=%0d exp=31", pht_index); end
    total++; if (prediction !== 2'b11) begin bad++; $display("FAIL train_pred got=%b exp=11", prediction); end
    total++; if (btb_hit !== 1'b1) begin bad++; $display("FAIL train_hit got=%b exp=1", btb_hit); end
    total++; if (pc_prediction !== 32'h200) begin bad++; $display("FAIL train_next got=%h exp=200", pc_prediction); end
  endtask

  task automatic test_alias();
    drive(32'h180, 0, 0, 0, 0, 0, 0, 0);
    #1;
    total++; if (btb_hit !== 1'b0) begin bad++; $display("FAIL alias_hit got=%b exp=0", btb_hit); end
    total++; if (pc_prediction !== 32'h184) begin bad++; $display("FAIL alias_next got=%h exp=184", pc_prediction); end
  endtask

  task automatic test_ghr();
    apply_reset();
    drive(32'h0, 1, 32'h300, 5'd3, 1, 32'h400, 0, 0); commit();
    drive(32'h0, 1, 32'h300, 5'd3, 0, 32'h400, 0, 0); commit();
    drive(32'h0, 1, 32'h300, 5'd3, 1, 32'h400, 0, 0); commit();
    drive(32'h100, 0, 0, 0, 0, 0, 0, 0);
    #1;
    total++; if (pht_index !== 5'h05) begin bad++; $display("FAIL ghr_idx got=%h exp=05", pht_index); end
    drive(32'h100, 1, 32'h300, 5'd3, 1, 32'h400, 0, 1); commit();
    drive(32'h100, 0, 0, 0, 0, 0, 0, 0);
    #1;
    total++; if (pht_index !== 5'h00) begin bad++; $display("FAIL ghr_clear_idx got=%h exp=00", pht_index); end
    total++; if (branch_count !== 32'd4) begin bad++; $display("FAIL ghr_clear_count got=%0d exp=4", branch_count); end
  endtask

  task automatic test_stats();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      drive(32'h0, 1, 32'h500 + 32'(i * 4), 5'(i), 1'(i % 2), 32'h600, (i < 4), 0);
      commit();
    end
    drive(32'h0, 0, 0, 0, 0, 0, 1, 0);
    #1;
    total++; if (branch_count !== 32'd10) begin bad++; $display("FAIL stats_branch got=%0d exp=10", branch_count); end
    total++; if (mispredict_count !== 32'd4) begin bad++; $display("FAIL stats_misp got=%0d exp=4", mispredict_count); end
    // mispredict without update must not count
    commit();
    drive(32'h0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    total++; if (mispredict_count !== 32'd4) begin bad++; $display("FAIL stats_idle_misp got=%0d exp=4", mispredict_count); end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    force dut.branch_count_q = 32'hFFFF_FFFF;
    force dut.mispredict_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.branch_count_q;
    release dut.mispredict_count_q;
    m_bc = 64'hFFFF_FFFF; m_mc = 64'hFFFF_FFFF;
    drive(32'h0, 1, 32'h700, 5'd7, 1, 32'h800, 1, 0); commit();
    drive(32'h0, 1, 32'h700, 5'd7, 0, 32'h800, 1, 0); commit();
    drive(32'h0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    total++; if (branch_count !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_branch got=%h exp=ffffffff", branch_count); end
    total++; if (mispredict_count !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_misp got=%h exp=ffffffff", mispredict_count); end
  endtask

  // Inputs are applied before the compare, so an update to the looked-up entry
  // also checks that the lookup shows pre-update state.
  task automatic test_random();
    logic [31:0] cpc, pu;
    apply_reset();
    for (int it = 0; it < 400; it++) begin
      cpc = ($urandom & 32'hFFFF_8000) | (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 31)) << 2);
      if (it % 50 == 7) cpc = 32'hFFFF_FFFC;
      pu  = ($urandom & 32'hFFFF_8000) | (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 31)) << 2);
      if (it % 3 == 0) pu = cpc;
      drive(cpc, ($urandom_range(0, 3) != 0), pu,
            (it % 2 == 0) ? model_idx(pu) : 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) == 0));
      #1;
      model_lookup(cpc);
      total++; if (pht_index !== e_idx) begin bad++; $display("FAIL rnd_idx it=%0d got=%h exp=%h", it, pht_index, e_idx); end
      total++; if (prediction !== e_pred) begin bad++; $display("FAIL rnd_pred it=%0d got=%b exp=%b", it, prediction, e_pred); end
      total++; if (predict_taken !== e_pred[1]) begin bad++; $display("FAIL rnd_taken it=%0d got=%b exp=%b", it, predict_taken, e_pred[1]); end
      total++; if (btb_hit !== e_hit) begin bad++; $display("FAIL rnd_hit it=%0d got=%b exp=%b", it, btb_hit, e_hit); end
      total++; if (pc_prediction !== e_next) begin bad++; $display("FAIL rnd_next it=%0d got=%h exp=%h", it, pc_prediction, e_next); end
      total++; if (branch_count !== 32'(m_bc) || mispredict_count !== 32'(m_mc)) begin
        bad++; $display("FAIL rnd_counts it=%0d got=%0d/%0d exp=%0d/%0d", it, branch_count, mispredict_count, m_bc, m_mc); end
      commit();
    end
  endtask

  task automatic test_async_reset();
    drive(32'h100, 1, 32'h100, model_idx(32'h100), 1, 32'h200, 1, 0); commit();
    drive(32'h100, 1, 32'h100, model_idx(32'h100), 1, 32'h200, 1, 0); commit();
    drive(32'h100, 1, 32'h100, model_idx(32'h100), 1, 32'h200, 1, 0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    total++; if (btb_hit !== 1'b0) begin bad++; $display("FAIL arst_hit got=%b exp=0", btb_hit); end
    total++; if (prediction !== 2'b01) begin bad++; $display("FAIL arst_pred got=%b exp=01", prediction); end
    total++; if (pc_prediction !== 32'h104) begin bad++; $display("FAIL arst_next got=%h exp=104", pc_prediction); end
    total++; if (pht_index !== 5'd0) begin bad++; $display("FAIL arst_idx got=%h exp=00", pht_index); end
    total++; if (branch_count !== 32'd0 || mispredict_count !== 32'd0) begin
      bad++; $display("FAIL arst_counts got=%0d/%0d exp=0/0", branch_count, mispredict_count); end
    @(posedge clk);
    @(negedge clk);
    update = 1'b0; mispredict = 1'b0;
    rst = 1'b1;
    #1;
    total++; if (prediction !== 2'b01 || branch_count !== 32'd0 || btb_hit !== 1'b0) begin
      bad++; $display("FAIL arst_discard got=%b/%0d/%b exp=01/0/0", prediction, branch_count, btb_hit); end
  endtask

  initial begin
    test_reset();
    test_training();
    test_alias();
    test_ghr();
    test_stats();
    test_saturation();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
